// File: rtl/ps2_keyboard_mmio_pkg.sv
// rtl/ps2_keyboard_mmio_pkg.sv - shared key codes, scancode constants and receiver states
package ps2_keyboard_mmio_pkg;

    localparam logic [15:0] KEY_SPACE     = 16'd32;
    localparam logic [15:0] KEY_ENTER     = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_ESC       = 16'd140;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/ps2_scancode_map.sv
// rtl/ps2_scancode_map.sv - combinational set-2 scancode to Hack key-code ROM
module ps2_scancode_map
    import ps2_keyboard_mmio_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  scancode,
    input  logic        shift,
    output logic [15:0] code,
    output logic        valid
);

    logic [4:0] idx;
    logic       is_letter;
    logic       is_digit;

    always_comb begin
        code      = 16'd0;
        valid     = 1'b0;
        idx       = 5'd0;
        is_letter = 1'b0;
        is_digit  = 1'b0;
        if (ext) begin
            valid = 1'b1;
            case (scancode)
                8'h6B:   code = KEY_LEFT;
                8'h75:   code = KEY_UP;
                8'h74:   code = KEY_RIGHT;
                8'h72:   code = KEY_DOWN;
                default: valid = 1'b0;
            endcase
        end else begin
            valid = 1'b1;
            case (scancode)
                8'h1C: begin is_letter = 1'b1; idx = 5'd0;  end
                8'h32: begin is_letter = 1'b1; idx = 5'd1;  end
                8'h21: begin is_letter = 1'b1; idx = 5'd2;  end
                8'h23: begin is_letter = 1'b1; idx = 5'd3;  end
                8'h24: begin is_letter = 1'b1; idx = 5'd4;  end
                8'h2B: begin is_letter = 1'b1; idx = 5'd5;  end
                8'h34: begin is_letter = 1'b1; idx = 5'd6;  end
                8'h33: begin is_letter = 1'b1; idx = 5'd7;  end
                8'h43: begin is_letter = 1'b1; idx = 5'd8;  end
                8'h3B: begin is_letter = 1'b1; idx = 5'd9;  end
                8'h42: begin is_letter = 1'b1; idx = 5'd10; end
                8'h4B: begin is_letter = 1'b1; idx = 5'd11; end
                8'h3A: begin is_letter = 1'b1; idx = 5'd12; end
                8'h31: begin is_letter = 1'b1; idx = 5'd13; end
                8'h44: begin is_letter = 1'b1; idx = 5'd14; end
                8'h4D: begin is_letter = 1'b1; idx = 5'd15; end
                8'h15: begin is_letter = 1'b1; idx = 5'd16; end
                8'h2D: begin is_letter = 1'b1; idx = 5'd17; end
                8'h1B: begin is_letter = 1'b1; idx = 5'd18; end
                8'h2C: begin is_letter = 1'b1; idx = 5'd19; end
                8'h3C: begin is_letter = 1'b1; idx = 5'd20; end
                8'h2A: begin is_letter = 1'b1; idx = 5'd21; end
                8'h1D: begin is_letter = 1'b1; idx = 5'd22; end
                8'h22: begin is_letter = 1'b1; idx = 5'd23; end
                8'h35: begin is_letter = 1'b1; idx = 5'd24; end
                8'h1A: begin is_letter = 1'b1; idx = 5'd25; end
                8'h45: begin is_digit = 1'b1; idx = 5'd0; end
                8'h16: begin is_digit = 1'b1; idx = 5'd1; end
                8'h1E: begin is_digit = 1'b1; idx = 5'd2; end
                8'h26: begin is_digit = 1'b1; idx = 5'd3; end
                8'h25: begin is_digit = 1'b1; idx = 5'd4; end
                8'h2E: begin is_digit = 1'b1; idx = 5'd5; end
                8'h36: begin is_digit = 1'b1; idx = 5'd6; end
                8'h3D: begin is_digit = 1'b1; idx = 5'd7; end
                8'h3E: begin is_digit = 1'b1; idx = 5'd8; end
                8'h46: begin is_digit = 1'b1; idx = 5'd9; end
                8'h29:   code = KEY_SPACE;
                8'h5A:   code = KEY_ENTER;
                8'h66:   code = KEY_BACKSPACE;
                8'h76:   code = KEY_ESC;
                default: valid = 1'b0;
            endcase
            if (is_letter) begin
                code = (shift ? 16'd65 : 16'd97) + {11'd0, idx};
            end else if (is_digit) begin
                code = 16'd48 + {11'd0, idx};
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_mmio.sv
// rtl/ps2_keyboard_mmio.sv - PS/2 receiver and make/break decoder feeding the keyboard word
module ps2_keyboard_mmio
    import ps2_keyboard_mmio_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [14:0] KBD_ADDR       = 15'd24576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbd_in,
    output logic [14:0] kbd_address,
    output logic        kbd_load,
    output logic        frame_err
);

    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    // Sync flops reset high (bus idle level) so reset never fakes a falling edge.
    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic       fall;
    logic       din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall        = clk_sync[2] & ~clk_sync[1];
    assign din         = data_sync[1];
    assign kbd_address = KBD_ADDR;

    rx_state_t      state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           parity_ok;
    logic           byte_valid;
    logic [TW-1:0]  tmo_cnt;
    logic           timeout;

    assign timeout = (state != ST_IDLE) && !fall && (tmo_cnt == TMO_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (fall) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            parity_ok  <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!din) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_ok <= ^{shreg, din};
                        state     <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (din && parity_ok) byte_valid <= 1'b1;
                        else                  frame_err  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    logic        break_f;
    logic        ext_f;
    logic        shift_f;
    logic [8:0]  held;
    logic [15:0] map_code;
    logic        map_valid;

    ps2_scancode_map u_map (
        .ext      (ext_f),
        .scancode (shreg),
        .shift    (shift_f),
        .code     (map_code),
        .valid    (map_valid)
    );

    // Only the most recently made key owns the word; stale breaks are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            break_f  <= 1'b0;
            ext_f    <= 1'b0;
            shift_f  <= 1'b0;
            held     <= 9'd0;
            kbd_in   <= 16'd0;
            kbd_load <= 1'b0;
        end else begin
            kbd_load <= 1'b0;
            if (byte_valid) begin
                if (shreg == SC_BREAK) begin
                    break_f <= 1'b1;
                end else if (shreg == SC_EXT) begin
                    ext_f <= 1'b1;
                end else begin
                    break_f <= 1'b0;
                    ext_f   <= 1'b0;
                    if (shreg == SC_LSHIFT || shreg == SC_RSHIFT) begin
                        shift_f <= !break_f;
                    end else if (map_valid) begin
                        if (!break_f) begin
                            held     <= {ext_f, shreg};
                            kbd_in   <= map_code;
                            kbd_load <= 1'b1;
                        end else if (held == {ext_f, shreg}) begin
                            held     <= 9'd0;
                            kbd_in   <= 16'd0;
                            kbd_load <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// tb/tb_ps2_keyboard_mmio.sv - vector, corner-case and randomized checks of ps2_keyboard_mmio
module tb_ps2_keyboard_mmio;

    localparam int TMO  = 300;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] kbd_in;
    logic [14:0] kbd_address;
    logic        kbd_load;
    logic        frame_err;

    ps2_keyboard_mmio #(.TIMEOUT_CYCLES(TMO), .KBD_ADDR(15'd24576)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .kbd_in      (kbd_in),
        .kbd_address (kbd_address),
        .kbd_load    (kbd_load),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [15:0] loads_q[$];
    int          err_cnt = 0;
    logic        prev_load = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (kbd_load) begin
                loads_q.push_back(kbd_in);
                chk("load_not_back_to_back", int'(prev_load), 0);
            end
            if (frame_err) err_cnt++;
            prev_load = kbd_load;
        end else begin
            prev_load = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit badpar);
        logic [10:0] bits;
        logic        p;
        p = ~^b;
        if (badpar) p = ~p;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic partial_frame(input int nbits);
        for (int i = 0; i <= nbits; i++) begin
            ps2_data = (i == 0) ? 1'b0 : i[0];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Reference model: spec-level key map and make/break rules.
    logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    function automatic int ref_code(input bit e, input logic [7:0] sc, input bit sh);
        if (e) begin
            case (sc)
                8'h6B: return 130;
                8'h75: return 131;
                8'h74: return 132;
                8'h72: return 133;
                default: return -1;
            endcase
        end
        for (int i = 0; i < 26; i++) if (letters[i] == sc) return (sh ? 65 : 97) + i;
        for (int i = 0; i < 10; i++) if (digits[i] == sc) return 48 + i;
        case (sc)
            8'h29: return 32;
            8'h5A: return 128;
            8'h66: return 129;
            8'h76: return 140;
            default: return -1;
        endcase
    endfunction

    bit m_brk, m_ext, m_sh;
    int m_held;
    int exp_q[$];

    task automatic model_byte(input logic [7:0] b);
        int c;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (b == 8'h12 || b == 8'h59) m_sh = !m_brk;
            else begin
                c = ref_code(m_ext, b, m_sh);
                if (c >= 0) begin
                    if (!m_brk) begin
                        m_held = {m_ext, b};
                        exp_q.push_back(c);
                    end else if (m_held == int'({m_ext, b})) begin
                        m_held = 0;
                        exp_q.push_back(0);
                    end
                end
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    typedef struct {
        logic [23:0] bs;
        int          n;
        bit          badpar;
        int          loads;
        int          last;
        int          errs;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] pool[22] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h76,
                             8'h12, 8'h59, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'h6B, 8'h75, 8'h74,
                             8'h72, 8'h0E};

    initial begin
        int l0, e0, last_exp, nb;
        logic [7:0] b;
        bit bad;

        vecs.push_back('{24'h00001C, 1, 1'b0, 1, 97, 0});
        vecs.push_back('{24'h001CF0, 2, 1'b0, 1, 0, 0});
        vecs.push_back('{24'h000012, 1, 1'b0, 0, 0, 0});
        vecs.push_back('{24'h00001C, 1, 1'b0, 1, 65, 0});
        vecs.push_back('{24'h001CF0, 2, 1'b0, 1, 0, 0});
        vecs.push_back('{24'h0012F0, 2, 1'b0, 0, 0, 0});
        vecs.push_back('{24'h006BE0, 2, 1'b0, 1, 130, 0});
        vecs.push_back('{24'h6BF0E0, 3, 1'b0, 1, 0, 0});
        vecs.push_back('{24'h001C1C, 2, 1'b0, 2, 97, 0});
        vecs.push_back('{24'h000045, 1, 1'b0, 1, 48, 0});
        vecs.push_back('{24'h00001C, 1, 1'b1, 0, 48, 1});
        vecs.push_back('{24'h0045F0, 2, 1'b0, 1, 0, 0});
        vecs.push_back('{24'h00006B, 1, 1'b0, 0, 0, 0});
        vecs.push_back('{24'h001CE0, 2, 1'b0, 0, 0, 0});
        vecs.push_back('{24'h006629, 2, 1'b0, 2, 129, 0});
        vecs.push_back('{24'h0029F0, 2, 1'b0, 0, 129, 0});
        vecs.push_back('{24'h000076, 1, 1'b0, 1, 140, 0});
        vecs.push_back('{24'h0076F0, 2, 1'b0, 1, 0, 0});

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_kbd_in", int'(kbd_in), 0);
        chk("reset_kbd_load", int'(kbd_load), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("kbd_address", int'(kbd_address), 24576);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        foreach (vecs[i]) begin
            l0 = loads_q.size();
            e0 = err_cnt;
            for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].bs[8*k +: 8], vecs[i].badpar);
            repeat (10) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_loads", i), loads_q.size() - l0, vecs[i].loads);
            chk($sformatf("vec%0d_kbd_in", i), int'(kbd_in), vecs[i].last);
            chk($sformatf("vec%0d_errs", i), err_cnt - e0, vecs[i].errs);
        end

        // Timeout mid-frame, then a clean frame must still decode.
        l0 = loads_q.size();
        e0 = err_cnt;
        partial_frame(3);
        repeat (TMO + 50) @(posedge clk);
        @(negedge clk);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_state_idle", int'(dut.state == ps2_keyboard_mmio_pkg::ST_IDLE), 1);
        send_byte(8'h29, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("after_timeout_loads", loads_q.size() - l0, 1);
        chk("after_timeout_kbd_in", int'(kbd_in), 32);

        // Reset in the middle of a frame.
        send_byte(8'h1C, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_kbd_in", int'(kbd_in), 97);
        partial_frame(2);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_kbd_in", int'(kbd_in), 0);
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        l0 = loads_q.size();
        send_byte(8'h5A, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("post_reset_loads", loads_q.size() - l0, 1);
        chk("post_reset_kbd_in", int'(kbd_in), 128);

        // Randomized byte stream against the reference model.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        loads_q.delete();
        exp_q.delete();
        e0 = err_cnt;
        nb = 0;
        m_brk = 0; m_ext = 0; m_sh = 0; m_held = 0;
        for (int i = 0; i < 80; i++) begin
            b = pool[$urandom_range(0, 21)];
            bad = ($urandom_range(0, 99) < 8);
            if (bad) nb++;
            else model_byte(b);
            send_byte(b, bad);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rand_loads", loads_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < loads_q.size(); i++)
            chk($sformatf("rand_load%0d", i), int'(loads_q[i]), exp_q[i]);
        last_exp = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : 0;
        chk("rand_final_kbd_in", int'(kbd_in), last_exp);
        chk("rand_errs", err_cnt - e0, nb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
